// File: rtl/serial_alu_wide_if.sv
// serial_alu_wide_if: operand/handshake/result bundle for the bit-serial wide ALU.
// The master drives start and operands; the slave (the ALU) returns status and results.
`timescale 1ns/1ps
interface serial_alu_wide_if #(
  parameter int WORD_BITS = 16,
  parameter int NSHIFT    = 2
);
  localparam int STEPS = WORD_BITS / NSHIFT;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  logic                 start_i;
  logic [3:0]           op_i;
  logic                 half_i;
  logic [1:0]           b_ext_i;
  logic [WORD_BITS-1:0] a_i;
  logic [WORD_BITS-1:0] b_i;
  logic                 busy_o;
  logic                 done_o;
  logic [WORD_BITS-1:0] result_o;
  logic                 flag_c_o;
  logic                 flag_v_o;
  logic                 flag_s_o;
  logic                 flag_z_o;
  logic [CW-1:0]        counter_o;

  modport master (
    output start_i, op_i, half_i, b_ext_i, a_i, b_i,
    input  busy_o, done_o, result_o, flag_c_o, flag_v_o, flag_s_o, flag_z_o, counter_o
  );

  modport slave (
    input  start_i, op_i, half_i, b_ext_i, a_i, b_i,
    output busy_o, done_o, result_o, flag_c_o, flag_v_o, flag_s_o, flag_z_o, counter_o
  );
endinterface

// File: rtl/serial_alu_wide.sv
// serial_alu_wide: bit-serial ALU processing NSHIFT bits per cycle, LSB first.
// Full- or half-word length, optional zero/sign extension of b, C/V/S/Z flags.
// Optional feature macro: SERIAL_ALU_MUL_EN adds op 9, an unsigned shift-add multiply
// of the low half-length operands; without it op 9 behaves as a reserved opcode.
`timescale 1ns/1ps
module serial_alu_wide #(
  parameter int WORD_BITS = 16,
  parameter int NSHIFT    = 2
) (
  input  logic              clk,
  input  logic              reset,
  serial_alu_wide_if.slave  bus
);

  localparam int HALFW  = WORD_BITS / 2;
  localparam int QUARTW = WORD_BITS / 4;
  localparam int STEPS  = WORD_BITS / NSHIFT;
  localparam int CW     = (STEPS > 1) ? $clog2(STEPS) : 1;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_ADC = 4'd2;
  localparam logic [3:0] OP_SBC = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_MOV = 4'd7;
  localparam logic [3:0] OP_CMP = 4'd8;
`ifdef SERIAL_ALU_MUL_EN
  localparam logic [3:0] OP_MUL = 4'd9;
`endif

  typedef enum logic {ST_IDLE, ST_RUN} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        counter_q, counter_d;
  logic [WORD_BITS-1:0] aSh_q, aSh_d;
  logic [WORD_BITS-1:0] bSh_q, bSh_d;
  logic [WORD_BITS-1:0] resSh_q, resSh_d;
  logic [WORD_BITS-1:0] result_q, result_d;
  logic                 carry_q, carry_d;
  logic                 zAcc_q, zAcc_d;
  logic                 half_q, half_d;
  logic [3:0]           op_q, op_d;
  logic                 flagC_q, flagC_d;
  logic                 flagV_q, flagV_d;
  logic                 flagS_q, flagS_d;
  logic                 flagZ_q, flagZ_d;

  int                   stepCnt;
  int                   extLo;
  int                   extHi;
  logic [CW-1:0]        lastIdx;
  logic                 isDone;
  logic                 accept;
  logic                 signBit;
  logic [WORD_BITS-1:0] bExt;
  logic [NSHIFT-1:0]    stepA, stepB, stepSum, stepRes;
  logic                 stepCin, carryTop, carryOut, bBit, subLike, zStep;
  logic [WORD_BITS-1:0] resShifted, finalRes;
`ifdef SERIAL_ALU_MUL_EN
  logic [WORD_BITS-1:0] mulMask, mulPartial, mulAcc;
`endif

  // Index of the final RUN step for the latched length and opcode
  always_comb begin
    stepCnt = half_q ? (STEPS / 2) : STEPS;
`ifdef SERIAL_ALU_MUL_EN
    if (op_q == OP_MUL) stepCnt = stepCnt / 2;
`endif
    lastIdx = CW'(stepCnt - 1);
  end

  assign isDone = (state_q == ST_RUN) && (counter_q == lastIdx);
  assign accept = bus.start_i && ((state_q == ST_IDLE) || isDone);

  // Zero/sign extension of the upper half of the active length of b, applied at load
  always_comb begin
    signBit = bus.half_i ? bus.b_i[QUARTW-1] : bus.b_i[HALFW-1];
    extLo   = bus.half_i ? QUARTW : HALFW;
    extHi   = bus.half_i ? HALFW : WORD_BITS;
    bExt    = bus.b_i;
    for (int i = 0; i < WORD_BITS; i++) begin
      if (i >= extLo && i < extHi) begin
        if (bus.b_ext_i == 2'b01) bExt[i] = 1'b0;
        else if (bus.b_ext_i == 2'b10) bExt[i] = signBit;
      end
    end
  end

  // One NSHIFT-bit slice of the add/logic datapath with its local ripple carry
  always_comb begin
    stepA    = aSh_q[NSHIFT-1:0];
    stepB    = bSh_q[NSHIFT-1:0];
    subLike  = (op_q == OP_SUB) || (op_q == OP_SBC) || (op_q == OP_CMP);
    stepCin  = carry_q;
    if (counter_q == '0) begin
      case (op_q)
        OP_SUB, OP_CMP: stepCin = 1'b1;
        OP_ADC, OP_SBC: stepCin = flagC_q;
        default:        stepCin = 1'b0;
      endcase
    end
    stepSum  = '0;
    carryTop = 1'b0;
    bBit     = 1'b0;
    carryOut = stepCin;
    for (int j = 0; j < NSHIFT; j++) begin
      bBit       = stepB[j] ^ subLike;
      stepSum[j] = stepA[j] ^ bBit ^ carryOut;
      if (j == NSHIFT - 1) carryTop = carryOut;
      carryOut   = (stepA[j] & bBit) | (stepA[j] & carryOut) | (bBit & carryOut);
    end
    case (op_q)
      OP_AND:  stepRes = stepA & stepB;
      OP_OR:   stepRes = stepA | stepB;
      OP_XOR:  stepRes = stepA ^ stepB;
      OP_MOV:  stepRes = stepB;
      default: stepRes = stepSum;
    endcase
    zStep      = ((counter_q == '0) ? 1'b1 : zAcc_q) & (stepRes == '0);
    resShifted = {stepRes, resSh_q[WORD_BITS-1:NSHIFT]};
    finalRes   = half_q ? (resShifted >> HALFW) : resShifted;
  end

`ifdef SERIAL_ALU_MUL_EN
  // Shift-add multiply slice: NSHIFT multiplier bits select shifted multiplicand copies
  always_comb begin
    mulMask = bus.half_i ? ((WORD_BITS'(1) << QUARTW) - WORD_BITS'(1))
                         : ((WORD_BITS'(1) << HALFW) - WORD_BITS'(1));
    mulPartial = '0;
    for (int j = 0; j < NSHIFT; j++) begin
      if (bSh_q[j]) mulPartial = mulPartial + (aSh_q << j);
    end
    mulAcc = resSh_q + mulPartial;
  end
`endif

  // Next-state: advance the serial step, commit on the done cycle, load on accepted start
  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    aSh_d     = aSh_q;
    bSh_d     = bSh_q;
    resSh_d   = resSh_q;
    result_d  = result_q;
    carry_d   = carry_q;
    zAcc_d    = zAcc_q;
    half_d    = half_q;
    op_d      = op_q;
    flagC_d   = flagC_q;
    flagV_d   = flagV_q;
    flagS_d   = flagS_q;
    flagZ_d   = flagZ_q;

    case (state_q)
      ST_IDLE: ;
      ST_RUN: begin
        counter_d = counter_q + CW'(1);
        carry_d   = carryOut;
        zAcc_d    = zStep;
        aSh_d     = aSh_q >> NSHIFT;
        bSh_d     = bSh_q >> NSHIFT;
        resSh_d   = resShifted;
`ifdef SERIAL_ALU_MUL_EN
        if (op_q == OP_MUL) begin
          aSh_d   = aSh_q << NSHIFT;
          resSh_d = mulAcc;
        end
`endif
        if (isDone) begin
          case (op_q)
            OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
              result_d = finalRes;
              flagC_d  = carryOut;
              flagV_d  = carryTop ^ carryOut;
              flagS_d  = stepRes[NSHIFT-1];
              flagZ_d  = zStep;
            end
            OP_CMP: begin
              flagC_d  = carryOut;
              flagV_d  = carryTop ^ carryOut;
              flagS_d  = stepRes[NSHIFT-1];
              flagZ_d  = zStep;
            end
            OP_AND, OP_OR, OP_XOR, OP_MOV: begin
              result_d = finalRes;
              flagS_d  = stepRes[NSHIFT-1];
              flagZ_d  = zStep;
            end
`ifdef SERIAL_ALU_MUL_EN
            OP_MUL: begin
              result_d = mulAcc;
              flagC_d  = 1'b0;
              flagV_d  = 1'b0;
              flagS_d  = half_q ? mulAcc[HALFW-1] : mulAcc[WORD_BITS-1];
              flagZ_d  = (mulAcc == '0);
            end
`endif
            default: ;
          endcase
          state_d   = ST_IDLE;
          counter_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      state_d   = ST_RUN;
      counter_d = '0;
      op_d      = bus.op_i;
      half_d    = bus.half_i;
      aSh_d     = bus.a_i;
      bSh_d     = bExt;
      resSh_d   = '0;
`ifdef SERIAL_ALU_MUL_EN
      if (bus.op_i == OP_MUL) begin
        aSh_d = bus.a_i & mulMask;
        bSh_d = bus.b_i & mulMask;
      end
`endif
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      counter_q <= '0;
      aSh_q     <= '0;
      bSh_q     <= '0;
      resSh_q   <= '0;
      result_q  <= '0;
      carry_q   <= 1'b0;
      zAcc_q    <= 1'b0;
      half_q    <= 1'b0;
      op_q      <= '0;
      flagC_q   <= 1'b0;
      flagV_q   <= 1'b0;
      flagS_q   <= 1'b0;
      flagZ_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      aSh_q     <= aSh_d;
      bSh_q     <= bSh_d;
      resSh_q   <= resSh_d;
      result_q  <= result_d;
      carry_q   <= carry_d;
      zAcc_q    <= zAcc_d;
      half_q    <= half_d;
      op_q      <= op_d;
      flagC_q   <= flagC_d;
      flagV_q   <= flagV_d;
      flagS_q   <= flagS_d;
      flagZ_q   <= flagZ_d;
    end
  end

  assign bus.busy_o    = (state_q == ST_RUN);
  assign bus.done_o    = isDone;
  assign bus.result_o  = result_q;
  assign bus.flag_c_o  = flagC_q;
  assign bus.flag_v_o  = flagV_q;
  assign bus.flag_s_o  = flagS_q;
  assign bus.flag_z_o  = flagZ_q;
  assign bus.counter_o = counter_q;

endmodule
